// File: rtl/fpaa_prog_sequencer.sv
// Serializes floating-gate switch programming: latches one target per command,
// settles the decoders/drain enables, fires timed Vinj pulses, then holds and releases.
module fpaa_prog_sequencer #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 5,
  parameter int NUM_ROWS = 12,
  parameter int NUM_COLS = 19,
  parameter int CNT_W    = 8,
  parameter int WID_W    = 12,
  parameter int SETTLE   = 4,
  parameter int GAP      = 2,
  parameter int HOLD     = 2
) (
  input  logic                clk,
  input  logic                reset,
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only while idle, so at most one
  // command is in flight and the offered fields are sampled only on that edge.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_island,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [CNT_W-1:0]    cmd_pulses,
  input  logic [WID_W-1:0]    cmd_width,
  input  logic                abort,
  output logic                island_sel,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                drain_sel_en,
  output logic                prog_en,
  output logic                vinj_pulse,
  output logic [CNT_W-1:0]    pulses_done,
  output logic                done,
  output logic                err,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_GAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  // Timer must cover both the pulse width field and the fixed phase lengths.
  localparam int TMR_W = (WID_W > 8) ? WID_W : 8;
  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] GAP_M1    = TMR_W'(GAP - 1);
  localparam logic [TMR_W-1:0] HOLD_M1   = TMR_W'(HOLD - 1);
  localparam logic [ROW_BITS:0] ROW_LIM  = (ROW_BITS + 1)'(NUM_ROWS);
  localparam logic [COL_BITS:0] COL_LIM  = (COL_BITS + 1)'(NUM_COLS);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   lat_wm1;
  logic [CNT_W-1:0]   lat_pulses;
  logic               aborted;

  logic               cmd_legal;
  logic [WID_W-1:0]   cmd_wid_m1;
  logic [CNT_W-1:0]   pd_inc;

  assign cmd_legal  = ({1'b0, cmd_row} < ROW_LIM) && ({1'b0, cmd_col} < COL_LIM);
  // A zero width is stretched to a single-cycle pulse.
  assign cmd_wid_m1 = (cmd_width == '0) ? '0 : cmd_width - 1'b1;
  assign pd_inc     = (pulses_done == '1) ? pulses_done : pulses_done + 1'b1;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      island_sel   <= 1'b0;
      row_addr     <= '0;
      col_addr     <= '0;
      dec_en       <= 1'b0;
      drain_sel_en <= 1'b0;
      prog_en      <= 1'b0;
      vinj_pulse   <= 1'b0;
      pulses_done  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      timer        <= '0;
      lat_wm1      <= '0;
      lat_pulses   <= '0;
      aborted      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            pulses_done <= '0;
            aborted     <= 1'b0;
            if (cmd_legal) begin
              island_sel   <= cmd_island;
              row_addr     <= cmd_row;
              col_addr     <= cmd_col;
              lat_pulses   <= cmd_pulses;
              lat_wm1      <= TMR_W'(cmd_wid_m1);
              dec_en       <= 1'b1;
              drain_sel_en <= 1'b1;
              prog_en      <= 1'b1;
              timer        <= SETTLE_M1;
              state        <= S_SETUP;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end

        S_SETUP: begin
          if (abort) begin
            aborted <= 1'b1;
            timer   <= HOLD_M1;
            state   <= S_RELEASE;
          end else if (timer == '0) begin
            if (lat_pulses == '0) begin
              timer <= HOLD_M1;
              state <= S_RELEASE;
            end else begin
              vinj_pulse <= 1'b1;
              timer      <= lat_wm1;
              state      <= S_PULSE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_PULSE: begin
          if (abort) begin
            vinj_pulse <= 1'b0;
            aborted    <= 1'b1;
            timer      <= HOLD_M1;
            state      <= S_RELEASE;
          end else if (timer == '0) begin
            vinj_pulse  <= 1'b0;
            pulses_done <= pd_inc;
            if (pd_inc == lat_pulses) begin
              timer <= HOLD_M1;
              state <= S_RELEASE;
            end else begin
              timer <= GAP_M1;
              state <= S_GAP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_GAP: begin
          if (abort) begin
            aborted <= 1'b1;
            timer   <= HOLD_M1;
            state   <= S_RELEASE;
          end else if (timer == '0) begin
            vinj_pulse <= 1'b1;
            timer      <= lat_wm1;
            state      <= S_PULSE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        // Pulse is already low here; enables stay up for the hold time.
        S_RELEASE: begin
          if (timer == '0) begin
            dec_en       <= 1'b0;
            drain_sel_en <= 1'b0;
            prog_en      <= 1'b0;
            if (aborted) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          aborted   <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          dec_en       <= 1'b0;
          drain_sel_en <= 1'b0;
          prog_en      <= 1'b0;
          vinj_pulse   <= 1'b0;
          cmd_ready    <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpaa_prog_sequencer.sv
// Cycle-by-cycle check of fpaa_prog_sequencer against a timeline model built
// from pulse-start/pulse-end arithmetic, with directed and random commands.
module tb_fpaa_prog_sequencer;

  localparam int ROW_BITS = 6;
  localparam int COL_BITS = 5;
  localparam int NUM_ROWS = 12;
  localparam int NUM_COLS = 19;
  localparam int CNT_W    = 8;
  localparam int WID_W    = 12;
  localparam int SETTLE   = 4;
  localparam int GAP      = 2;
  localparam int HOLD     = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_island = 1'b0;
  logic [ROW_BITS-1:0] cmd_row = '0;
  logic [COL_BITS-1:0] cmd_col = '0;
  logic [CNT_W-1:0]    cmd_pulses = '0;
  logic [WID_W-1:0]    cmd_width = '0;
  logic                abort = 1'b0;
  logic                island_sel;
  logic [ROW_BITS-1:0] row_addr;
  logic [COL_BITS-1:0] col_addr;
  logic                dec_en, drain_sel_en, prog_en, vinj_pulse;
  logic [CNT_W-1:0]    pulses_done;
  logic                done, err, busy;
  logic [2:0]          dbg_state;

  fpaa_prog_sequencer #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS),
    .CNT_W(CNT_W), .WID_W(WID_W), .SETTLE(SETTLE), .GAP(GAP), .HOLD(HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_island(cmd_island),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulses(cmd_pulses), .cmd_width(cmd_width),
    .abort(abort), .island_sel(island_sel), .row_addr(row_addr), .col_addr(col_addr),
    .dec_en(dec_en), .drain_sel_en(drain_sel_en), .prog_en(prog_en), .vinj_pulse(vinj_pulse),
    .pulses_done(pulses_done), .done(done), .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Model of the latched target addresses.
  logic                m_isl = 1'b0;
  logic [ROW_BITS-1:0] m_row = '0;
  logic [COL_BITS-1:0] m_col = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string ctx, input int c, input logic e_ready, input logic e_busy,
                             input logic e_en, input logic e_vinj, input logic e_done,
                             input logic e_err, input int e_pd);
    string p;
    p = $sformatf("%s c%0d", ctx, c);
    check({p, " cmd_ready"}, 32'(cmd_ready), 32'(e_ready));
    check({p, " busy"}, 32'(busy), 32'(e_busy));
    check({p, " dec_en"}, 32'(dec_en), 32'(e_en));
    check({p, " drain_sel_en"}, 32'(drain_sel_en), 32'(e_en));
    check({p, " prog_en"}, 32'(prog_en), 32'(e_en));
    check({p, " vinj_pulse"}, 32'(vinj_pulse), 32'(e_vinj));
    check({p, " done"}, 32'(done), 32'(e_done));
    check({p, " err"}, 32'(err), 32'(e_err));
    check({p, " pulses_done"}, 32'(pulses_done), 32'(e_pd));
    check({p, " island_sel"}, 32'(island_sel), 32'(m_isl));
    check({p, " row_addr"}, 32'(row_addr), 32'(m_row));
    check({p, " col_addr"}, 32'(col_addr), 32'(m_col));
  endtask

  // Pulse i occupies cycles SETTLE+1+i*(w+GAP) .. SETTLE+i*(w+GAP)+w.
  function automatic bit in_pulse(input int c, input int n, input int w);
    int off;
    off = c - (SETTLE + 1);
    if (off < 0) return 1'b0;
    return ((off / (w + GAP)) < n) && ((off % (w + GAP)) < w);
  endfunction

  // A pulse counts from the cycle after its last high cycle, unless aborted in that cycle.
  function automatic int pulses_counted(input int c, input int n, input int w, input int ak);
    int limit, cnt;
    limit = (ak > 0 && ak < c) ? ak : c;
    cnt = 0;
    for (int i = 0; i < n; i++)
      if (SETTLE + i * (w + GAP) + w < limit) cnt++;
    return cnt;
  endfunction

  // driver: issue one command and check every cycle through the return of cmd_ready.
  task automatic run_cmd(input string name, input logic isl, input int row, input int col,
                         input int pulses, input int width, input int abort_k,
                         input int reset_k, input bit scramble);
    bit legal, aborted;
    int n, w, end_act, rel_start, fin;
    logic e_en, e_vinj;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_island = isl;
    cmd_row    = row[ROW_BITS-1:0];
    cmd_col    = col[COL_BITS-1:0];
    cmd_pulses = pulses[CNT_W-1:0];
    cmd_width  = width[WID_W-1:0];
    legal      = (row < NUM_ROWS) && (col < NUM_COLS);
    n          = pulses;
    w          = (width == 0) ? 1 : width;
    end_act    = SETTLE + n * w + ((n > 0) ? (n - 1) * GAP : 0);
    aborted    = legal && abort_k >= 1 && abort_k <= end_act;
    rel_start  = aborted ? abort_k + 1 : end_act + 1;
    fin        = legal ? rel_start + HOLD : 1;
    if (legal) begin
      m_isl = isl;
      m_row = row[ROW_BITS-1:0];
      m_col = col[COL_BITS-1:0];
    end
    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      e_en   = legal && (c < fin);
      e_vinj = legal && (c < rel_start) && in_pulse(c, n, w);
      check_cycle(name, c, c > fin, c <= fin, e_en, e_vinj,
                  legal && !aborted && c == fin, (c == fin) && (!legal || aborted),
                  legal ? pulses_counted(c, n, w, aborted ? abort_k : 0) : 0);
      abort = (c == abort_k);
      if (scramble && c <= fin) begin
        cmd_valid  = 1'b1;
        cmd_island = 1'($urandom);
        cmd_row    = ROW_BITS'($urandom);
        cmd_col    = COL_BITS'($urandom);
        cmd_pulses = CNT_W'($urandom);
        cmd_width  = WID_W'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (c == reset_k) begin
        reset = 1'b1;
        @(negedge clk);
        m_isl = 1'b0;
        m_row = '0;
        m_col = '0;
        check_cycle({name, " after-reset"}, c + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        return;
      end
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int isl, row, col, pulses, width, ak, est;
    // reset state
    repeat (3) @(negedge clk);
    check_cycle("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;

    // directed
    run_cmd("basic_3x5", 1'b1, 3, 8, 3, 5, 0, 0, 1'b0);
    run_cmd("zero_pulses", 1'b0, 5, 2, 0, 7, 0, 0, 1'b0);
    run_cmd("width0_x2", 1'b1, 11, 18, 2, 0, 0, 0, 1'b0);
    run_cmd("row_eq_num_rows", 1'b0, 12, 4, 3, 5, 0, 0, 1'b0);
    run_cmd("col_eq_num_cols", 1'b1, 2, 19, 1, 1, 0, 0, 1'b0);
    run_cmd("abort_c7", 1'b1, 3, 8, 3, 5, 7, 0, 1'b0);
    run_cmd("abort_in_release", 1'b0, 7, 9, 1, 3, 8, 0, 1'b0);
    run_cmd("abort_setup_c1", 1'b1, 0, 0, 2, 2, 1, 0, 1'b0);
    run_cmd("held_fields", 1'b1, 4, 6, 2, 3, 0, 0, 1'b1);
    run_cmd("reset_c14", 1'b1, 3, 8, 3, 5, 0, 14, 1'b1);
    run_cmd("after_reset", 1'b0, 9, 17, 2, 4, 0, 0, 1'b0);
    run_cmd("max_pulses", 1'b1, 1, 1, 255, 1, 0, 0, 1'b0);
    run_cmd("max_width", 1'b0, 10, 12, 1, 4095, 0, 0, 1'b0);

    // random
    for (int k = 0; k < 30; k++) begin
      isl    = $urandom_range(1, 0);
      row    = $urandom_range(13, 0);
      col    = $urandom_range(20, 0);
      pulses = $urandom_range(5, 0);
      width  = $urandom_range(6, 0);
      est    = SETTLE + pulses * ((width == 0) ? 1 : width) + pulses * GAP + HOLD + 1;
      ak     = ($urandom_range(2, 0) == 0) ? $urandom_range(est, 1) : 0;
      run_cmd($sformatf("rand%0d", k), isl[0], row, col, pulses, width, ak, 0,
              $urandom_range(1, 0) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
